alu_74181_serial: RTL and testbench

//  Nibble-serial, WIDTH-bit ALU. It reuses the SN74181 4-bit function set (16 logic and 16 arithmetic ops).
//  It processes one 4-bit slice per clock, LSB nibble first, and ripples the carry through a register.
//  It also accumulates word-level group propagate/generate across slices.

---
 rtl/alu_74181_serial_if.sv | 30 +++
 rtl/alu_74181_serial.sv | 139 +++++++++++++
 tb/tb_alu_74181_serial.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_74181_serial_if.sv
// Operand/result handshake bundle for the nibble-serial 74181 ALU.
// The master side is the host. The slave side is the ALU.
interface alu_74181_serial_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       s;
    logic             m;
    logic             cn;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] f;
    logic             cn4;
    logic             equal;
    logic             p;
    logic             g;

    modport master (
        output in_valid, a, b, s, m, cn, out_ready,
        input  in_ready, out_valid, f, cn4, equal, p, g
    );

    modport slave (
        input  in_valid, a, b, s, m, cn, out_ready,
        output in_ready, out_valid, f, cn4, equal, p, g
    );
endinterface

// File: rtl/alu_74181_serial.sv
// Nibble-serial SN74181-style ALU. It computes one 4-bit slice per clock, LSB first.
// A registered ripple carry joins the slices, and the word propagate/generate terms are accumulated as the slices run.
module alu_74181_serial #(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    alu_74181_serial_if.slave bus
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
            $error("alu_74181_serial: WIDTH must be a multiple of 4 and >= 8");
        end
    endgenerate

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       s_q;
    logic             m_q;
    logic             carry;
    logic             pacc;
    logic             gacc;
    logic [WIDTH-1:0] f_q;
    logic             cn4_q;
    logic             equal_q;
    logic             p_q;
    logic             g_q;
    logic             out_valid_q;

    logic [3:0] an;
    logic [3:0] bn;
    logic [3:0] x;
    logic [3:0] y;
    logic [4:0] c;
    logic [3:0] slice_f;
    logic       slice_p;
    logic       slice_g;
    logic       pacc_next;
    logic       gacc_next;

    // One 74181 slice. x is the per-bit propagate term and y is the per-bit generate term (y implies x).
    // The sum is x ^ y ^ carry. Logic mode is the complement of x ^ y.
    always_comb begin
        an = a_q[{cnt, 2'b00} +: 4];
        bn = b_q[{cnt, 2'b00} +: 4];
        x  = '0;
        y  = '0;
        c  = '0;
        c[0] = carry;
        for (int i = 0; i < 4; i++) begin
            x[i]   = an[i] | (bn[i] & s_q[0]) | (~bn[i] & s_q[1]);
            y[i]   = (an[i] & ~bn[i] & s_q[2]) | (an[i] & bn[i] & s_q[3]);
            c[i+1] = y[i] | (x[i] & c[i]);
        end
        slice_f   = m_q ? ~(x ^ y) : (x ^ y ^ c[3:0]);
        slice_p   = &x;
        slice_g   = y[3] | (x[3] & y[2]) | (x[3] & x[2] & y[1]) | (x[3] & x[2] & x[1] & y[0]);
        pacc_next = pacc & slice_p;
        gacc_next = slice_g | (slice_p & gacc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            m_q         <= 1'b0;
            carry       <= 1'b0;
            pacc        <= 1'b1;
            gacc        <= 1'b0;
            f_q         <= '0;
            cn4_q       <= 1'b1;
            equal_q     <= 1'b0;
            p_q         <= 1'b1;
            g_q         <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        s_q     <= bus.s;
                        m_q     <= bus.m;
                        carry   <= ~bus.cn;
                        pacc    <= 1'b1;
                        gacc    <= 1'b0;
                        equal_q <= (bus.a == bus.b);
                        cnt     <= '0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    f_q[{cnt, 2'b00} +: 4] <= slice_f;
                    carry <= c[4];
                    pacc  <= pacc_next;
                    gacc  <= gacc_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // Flags are exposed active-low and forced inactive in logic mode.
                        cn4_q       <= m_q | ~c[4];
                        p_q         <= m_q | ~pacc_next;
                        g_q         <= m_q | ~gacc_next;
                        cnt         <= '0;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.f         = f_q;
    assign bus.cn4       = cn4_q;
    assign bus.equal     = equal_q;
    assign bus.p         = p_q;
    assign bus.g         = g_q;
endmodule

// File: tb/tb_alu_74181_serial.sv
// Self-checking bench for alu_74181_serial (WIDTH = 16). It runs the directed scenarios and then random operations.
// Each result is checked against a word-level model of the 74181 function table.
module tb_alu_74181_serial;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_74181_serial_if #(.WIDTH(16)) bus ();

    alu_74181_serial #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Datasheet view: arithmetic result is X plus Y plus carry. X is the 74181 propagate operand and Y is the generate operand.
    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                                  input logic m, input logic cn, output logic [15:0] f,
                                  output logic cn4, output logic p, output logic g);
        logic [15:0] x, y;
        logic [16:0] sum, gen;
        f = '0; cn4 = 1'b1; p = 1'b1; g = 1'b1; x = '0; y = '0;
        if (m) begin
            case (s)
                4'd0:  f = ~a;
                4'd1:  f = ~(a | b);
                4'd2:  f = ~a & b;
                4'd3:  f = 16'h0000;
                4'd4:  f = ~(a & b);
                4'd5:  f = ~b;
                4'd6:  f = a ^ b;
                4'd7:  f = a & ~b;
                4'd8:  f = ~a | b;
                4'd9:  f = ~(a ^ b);
                4'd10: f = b;
                4'd11: f = a & b;
                4'd12: f = 16'hFFFF;
                4'd13: f = a | ~b;
                4'd14: f = a | b;
                default: f = a;
            endcase
        end else begin
            case (s)
                4'd0:  begin x = a;        y = 16'h0000; end
                4'd1:  begin x = a | b;    y = 16'h0000; end
                4'd2:  begin x = a | ~b;   y = 16'h0000; end
                4'd3:  begin x = 16'hFFFF; y = 16'h0000; end
                4'd4:  begin x = a;        y = a & ~b;   end
                4'd5:  begin x = a | b;    y = a & ~b;   end
                4'd6:  begin x = a | ~b;   y = a & ~b;   end
                4'd7:  begin x = 16'hFFFF; y = a & ~b;   end
                4'd8:  begin x = a;        y = a & b;    end
                4'd9:  begin x = a | b;    y = a & b;    end
                4'd10: begin x = a | ~b;   y = a & b;    end
                4'd11: begin x = 16'hFFFF; y = a & b;    end
                4'd12: begin x = a;        y = a;        end
                4'd13: begin x = a | b;    y = a;        end
                4'd14: begin x = a | ~b;   y = a;        end
                default: begin x = 16'hFFFF; y = a;      end
            endcase
            sum = {1'b0, x} + {1'b0, y} + {16'b0, ~cn};
            gen = {1'b0, x} + {1'b0, y};
            f   = sum[15:0];
            cn4 = ~sum[16];
            g   = ~gen[16];
            p   = ~(x == 16'hFFFF);
        end
    endfunction

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                                 input logic m, input logic cn, output int lat);
        @(negedge clk);
        bus.a = a; bus.b = b; bus.s = s; bus.m = m; bus.cn = cn;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a = 16'($urandom); bus.b = 16'($urandom);
        bus.s = 4'($urandom);  bus.m = 1'($urandom); bus.cn = 1'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] a, input logic [15:0] b,
                               input logic [3:0] s, input logic m, input logic cn, input int lat);
        logic [15:0] ef;
        logic ec, ep, eg;
        model(a, b, s, m, cn, ef, ec, ep, eg);
        checkValue($sformatf("%s_latency", tag), 32'(lat), 32'd4);
        checkValue($sformatf("%s_f", tag), 32'(bus.f), 32'(ef));
        checkValue($sformatf("%s_cn4", tag), 32'(bus.cn4), 32'(ec));
        checkValue($sformatf("%s_p", tag), 32'(bus.p), 32'(ep));
        checkValue($sformatf("%s_g", tag), 32'(bus.g), 32'(eg));
        checkValue($sformatf("%s_equal", tag), 32'(bus.equal), 32'(a == b));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkValue($sformatf("%s_rel_valid", tag), 32'(bus.out_valid), 32'd0);
        checkValue($sformatf("%s_rel_ready", tag), 32'(bus.in_ready), 32'd1);
    endtask

    task automatic runOp(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] s, input logic m, input logic cn);
        int lat;
        applyStimulus(a, b, s, m, cn, lat);
        checkOutput(tag, a, b, s, m, cn, lat);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        logic [15:0] ra, rb, ef;
        logic [3:0]  rs;
        logic        rm, rcn, ec, ep, eg;
        int          lat;

        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.s = '0; bus.m = 1'b0; bus.cn = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkValue("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkValue("rst_f", 32'(bus.f), 32'd0);
        checkValue("rst_cn4", 32'(bus.cn4), 32'd1);
        checkValue("rst_equal", 32'(bus.equal), 32'd0);
        checkValue("rst_p", 32'(bus.p), 32'd1);
        checkValue("rst_g", 32'(bus.g), 32'd1);
        checkValue("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;

        runOp("add", 16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1);
        runOp("ripple", 16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1);
        runOp("sub", 16'h5000, 16'h5000, 4'b0110, 1'b0, 1'b0);
        runOp("xor", 16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1);

        // Backpressure: the result must hold, and new bundles must be refused until the result is released.
        applyStimulus(16'hA5C3, 16'h3C5A, 4'b1001, 1'b0, 1'b0, lat);
        model(16'hA5C3, 16'h3C5A, 4'b1001, 1'b0, 1'b0, ef, ec, ep, eg);
        checkValue("bp_latency", 32'(lat), 32'd4);
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.a = 16'($urandom); bus.b = 16'($urandom);
            @(negedge clk);
            checkValue("bp_out_valid", 32'(bus.out_valid), 32'd1);
            checkValue("bp_in_ready", 32'(bus.in_ready), 32'd0);
            checkValue("bp_f", 32'(bus.f), 32'(ef));
            checkValue("bp_cn4", 32'(bus.cn4), 32'(ec));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checkValue("bp_rel_valid", 32'(bus.out_valid), 32'd0);
        checkValue("bp_rel_ready", 32'(bus.in_ready), 32'd1);

        // Reset arriving on the edge that would compute slice 2.
        bus.a = 16'h1234; bus.b = 16'h0FFF; bus.s = 4'b1001; bus.m = 1'b0; bus.cn = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkValue("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkValue("mid_rst_f", 32'(bus.f), 32'd0);
        checkValue("mid_rst_cn4", 32'(bus.cn4), 32'd1);
        checkValue("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        runOp("after_rst_add", 16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1);

        for (int n = 0; n < 40; n++) begin
            ra  = 16'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
            rs  = 4'($urandom);
            rm  = 1'($urandom);
            rcn = 1'($urandom);
            runOp($sformatf("rand%0d", n), ra, rb, rs, rm, rcn);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
